// File: rtl/cache_data_block_ram.sv
// rtl/cache_data_block_ram.sv - simple dual-port RAM with registered read, byte lanes and write-to-read bypass
module cache_data_block_ram #(
    parameter int data_bits   = 32,
    parameter int nr_entries  = 1024,
    parameter bit use_bytesel = 1'b1,
    localparam int addr_bits  = $clog2(nr_entries)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addr_bits-1:0] read_addr,
    output logic [data_bits-1:0] read_data,
    input  logic                 wr_en,
    input  logic [addr_bits-1:0] write_addr,
    input  logic [data_bits-1:0] write_data,
    input  logic [3:0]           bytesel
);

    // An address can only fall outside the array when the depth is not a power of two.
    localparam bit                 POW2      = (nr_entries == (1 << addr_bits));
    localparam logic [addr_bits:0] ENTRIES_W = (addr_bits + 1)'(nr_entries);

    logic [data_bits-1:0] mem_q [nr_entries] = '{default: '0};
    logic [data_bits-1:0] read_data_q;
    logic [data_bits-1:0] read_data_d;
    logic [data_bits-1:0] lane_mask;
    logic [data_bits-1:0] wr_old;
    logic [data_bits-1:0] wr_merged;
    logic [data_bits-1:0] rd_old;
    logic                 rd_in_range;
    logic                 wr_in_range;
    logic                 bypass;

    generate
        if (POW2) begin : g_full_range
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end else begin : g_partial_range
            assign rd_in_range = ({1'b0, read_addr} < ENTRIES_W);
            assign wr_in_range = ({1'b0, write_addr} < ENTRIES_W);
        end

        // Byte lanes only make sense for the 32-bit data array; narrow arrays write whole words.
        if (use_bytesel && data_bits == 32) begin : g_byte_lanes
            assign lane_mask = {{8{bytesel[3]}}, {8{bytesel[2]}},
                                {8{bytesel[1]}}, {8{bytesel[0]}}};
        end else begin : g_full_word
            logic unused_bytesel;
            assign unused_bytesel = ^bytesel;
            assign lane_mask      = '1;
        end
    endgenerate

    // Post-write word and next read value, including the same-address bypass.
    always_comb begin
        wr_old      = wr_in_range ? mem_q[write_addr] : '0;
        wr_merged   = (wr_old & ~lane_mask) | (write_data & lane_mask);
        rd_old      = rd_in_range ? mem_q[read_addr] : '0;
        bypass      = wr_en && wr_in_range && rd_in_range && (write_addr == read_addr);
        read_data_d = bypass ? wr_merged : rd_old;
    end

    // Array write; deliberately not gated by rst so invalidation sweeps can run during reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem_q[write_addr] <= wr_merged;
        end
    end

    // Registered read port, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_cache_data_block_ram.sv
// tb/tb_cache_data_block_ram.sv - self-checking bench for cache_data_block_ram
module tb_cache_data_block_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main 32-bit, 1024-entry instance
    logic        rst;
    logic [9:0]  ra, wa;
    logic [31:0] rd, wd;
    logic        we;
    logic [3:0]  bs;

    cache_data_block_ram #(.data_bits(32), .nr_entries(1024), .use_bytesel(1'b1)) u_main (
        .clk(clk), .rst(rst), .read_addr(ra), .read_data(rd), .wr_en(we),
        .write_addr(wa), .write_data(wd), .bytesel(bs)
    );

    // Narrow 1-bit, 128-entry instance
    logic       n_rst;
    logic [6:0] n_ra, n_wa;
    logic [0:0] n_rd, n_wd;
    logic       n_we;
    logic [3:0] n_bs;

    cache_data_block_ram #(.data_bits(1), .nr_entries(128), .use_bytesel(1'b1)) u_narrow (
        .clk(clk), .rst(n_rst), .read_addr(n_ra), .read_data(n_rd), .wr_en(n_we),
        .write_addr(n_wa), .write_data(n_wd), .bytesel(n_bs)
    );

    // Non-power-of-two 12-entry instance for out-of-range behaviour
    logic        o_rst;
    logic [3:0]  o_ra, o_wa;
    logic [31:0] o_rd, o_wd;
    logic        o_we;
    logic [3:0]  o_bs;

    cache_data_block_ram #(.data_bits(32), .nr_entries(12), .use_bytesel(1'b1)) u_oor (
        .clk(clk), .rst(o_rst), .read_addr(o_ra), .read_data(o_rd), .wr_en(o_we),
        .write_addr(o_wa), .write_data(o_wd), .bytesel(o_bs)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain word array, lane-by-lane merge.
    logic [31:0] model_mem [1024];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (sel[l]) r[8*l +: 8] = nw[8*l +: 8];
        end
        return r;
    endfunction

    typedef struct {
        logic        rst;
        logic        we;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic [3:0]  bs;
        logic [9:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic step_main;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; bs = '0; ra = '0;
        n_rst = 1'b1; n_we = 1'b0; n_wa = '0; n_wd = '0; n_bs = '0; n_ra = '0;
        o_rst = 1'b1; o_we = 1'b0; o_wa = '0; o_wd = '0; o_bs = '0; o_ra = '0;

        //          rst   we    wa  wd             bs       ra  exp
        vecs[0]  = '{1'b1, 1'b0, 0,  32'h0,         4'h0,    5,  32'h0};
        vecs[1]  = '{1'b0, 1'b0, 0,  32'h0,         4'h0,    5,  32'h0};
        vecs[2]  = '{1'b0, 1'b1, 3,  32'hDEADBEEF,  4'hF,    0,  32'h0};
        vecs[3]  = '{1'b0, 1'b0, 0,  32'h0,         4'h0,    3,  32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 7,  32'h11223344,  4'hF,    3,  32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b1, 7,  32'hAABBCCDD,  4'b0101, 7,  32'h11BB33DD};
        vecs[6]  = '{1'b0, 1'b1, 7,  32'hFFFFFFFF,  4'b0000, 7,  32'h11BB33DD};
        vecs[7]  = '{1'b0, 1'b0, 0,  32'h0,         4'h0,    7,  32'h11BB33DD};
        vecs[8]  = '{1'b0, 1'b1, 9,  32'hCAFEF00D,  4'b0011, 9,  32'h0000F00D};
        vecs[9]  = '{1'b0, 1'b0, 0,  32'h0,         4'h0,    9,  32'h0000F00D};
        vecs[10] = '{1'b0, 1'b1, 3,  32'h12345678,  4'hF,    7,  32'h11BB33DD};
        vecs[11] = '{1'b1, 1'b1, 10, 32'h00000001,  4'hF,    3,  32'h0};
        vecs[12] = '{1'b0, 1'b0, 0,  32'h0,         4'h0,    10, 32'h00000001};
        vecs[13] = '{1'b0, 1'b0, 0,  32'h0,         4'h0,    3,  32'h12345678};

        #1;
        check("reset_hold", rd, 32'h0);
        step_main;
        n_rst = 1'b0; o_rst = 1'b0;

        for (int v = 0; v < 14; v++) begin
            rst = vecs[v].rst; we = vecs[v].we; wa = vecs[v].wa;
            wd = vecs[v].wd; bs = vecs[v].bs; ra = vecs[v].ra;
            step_main;
            check($sformatf("vec%0d", v), rd, vecs[v].exp);
            if (vecs[v].we) model_mem[vecs[v].wa] = merge(model_mem[vecs[v].wa], vecs[v].wd, vecs[v].bs);
        end

        // Asynchronous reset clears read_data between edges.
        rst = 1'b0; we = 1'b0; ra = 10'd3;
        step_main;
        check("pre_async", rd, 32'h12345678);
        #2 rst = 1'b1;
        #1 check("async_rst", rd, 32'h0);
        step_main;
        check("rst_held", rd, 32'h0);
        rst = 1'b0;
        step_main;
        check("rst_release", rd, 32'h12345678);

        // Randomised traffic in a small window to force collisions, checked against the model.
        for (int it = 0; it < 400; it++) begin
            logic [31:0] exp_rd;
            rst = ($urandom_range(0, 19) == 0);
            we  = $urandom_range(0, 1);
            wa  = 10'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            wd  = $urandom;
            bs  = 4'($urandom_range(0, 15));
            if (rst) exp_rd = '0;
            else if (we && wa == ra) exp_rd = merge(model_mem[wa], wd, bs);
            else exp_rd = model_mem[ra];
            step_main;
            check($sformatf("rand%0d", it), rd, exp_rd);
            if (we) model_mem[wa] = merge(model_mem[wa], wd, bs);
        end
        rst = 1'b0; we = 1'b0;

        // Narrow instance: fill with 1 (bytesel deliberately zero), then clear entry 64.
        n_we = 1'b1; n_wd = 1'b1; n_bs = 4'b0000;
        for (int a = 0; a < 128; a++) begin
            n_wa = 7'(a);
            step_main;
        end
        n_wa = 7'd64; n_wd = 1'b0; n_bs = 4'b0000;
        step_main;
        n_we = 1'b0;
        for (int a = 63; a <= 65; a++) begin
            n_ra = 7'(a);
            step_main;
            check($sformatf("narrow%0d", a), 32'(n_rd), (a == 64) ? 32'h0 : 32'h1);
        end

        // Out-of-range addresses on a 12-entry array.
        o_we = 1'b1; o_wa = 4'd13; o_wd = 32'hA5A5A5A5; o_bs = 4'hF; o_ra = 4'd13;
        step_main;
        check("oor_bypass", o_rd, 32'h0);
        o_wa = 4'd11; o_wd = 32'h5A5A1234; o_ra = 4'd13;
        step_main;
        check("oor_read", o_rd, 32'h0);
        o_we = 1'b0; o_ra = 4'd11;
        step_main;
        check("inrange_last", o_rd, 32'h5A5A1234);
        o_we = 1'b1; o_wa = 4'd1; o_wd = 32'h77777777; o_ra = 4'd1;
        step_main;
        check("oor_alias", o_rd, 32'h77777777);
        o_we = 1'b0; o_ra = 4'd13;
        step_main;
        check("oor_read2", o_rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_data_block_ram.md
# cache_data_block_ram

Simple dual-port synchronous RAM used as the storage primitive of each cache way: tag, valid and dirty arrays (narrow words, no byte enables) and the 32-bit data array (byte-lane writes). One write port and one read port share a single clock. Read data is registered with one cycle of latency. A write-to-read bypass returns freshly written data when both ports hit the same address in the same cycle.

## Interface
Parameters:
- data_bits, 32, word width in bits. Must be ≥1.
- nr_entries, 1024, number of words. Must be ≥2.
- use_bytesel, 1, when 1 and data_bits==32, writes honour bytesel. Otherwise bytesel is ignored and full words are written.
- Derived: addr_bits = $clog2(nr_entries).

Ports:
- clk  in  1  sole clock; all sampling on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears the read_data register only.
- read_addr  in  addr_bits  read port address.
- read_data  out  data_bits  registered read data.
- wr_en  in  1  write strobe.
- write_addr  in  addr_bits  write port address.
- write_data  in  data_bits  write data.
- bytesel  in  4  byte-lane write enables. Lane i covers write_data[8i+7:8i].

## Operation
- Storage: nr_entries × data_bits array. Contents are zero at power-up/initialisation. rst does not clear the array.
- Write:
  - On a rising edge with wr_en=1, mem[write_addr] is updated.
  - Byte-enabled mode: only lanes with bytesel[i]=1 are replaced; other lanes keep their old contents.
  - bytesel=4'b0000 with wr_en=1 leaves the word unchanged.
  - Non-byte-enabled mode: the whole word is written.
- Writes are not gated by rst. The array may be written while rst is high, e.g. a valid-bit invalidation sweep during reset.
- Read:
  - On every rising edge with rst=0, read_data <= mem[read_addr].
  - There is no read enable; the read port always reads.
- Bypass: when wr_en=1 and write_addr==read_addr on the same edge, read_data gets the post-write value. Enabled lanes come from write_data; disabled lanes come from the old mem contents.
- Out-of-range addresses (≥ nr_entries, when nr_entries is not a power of 2):
  - Writes are ignored.
  - Reads return all zeros.
  - The bypass does not apply.
- Simultaneous write and read to different addresses are independent. The read returns the old contents of read_addr.

## Timing
- Read latency is 1 cycle. read_addr presented before edge N gives its data on read_data after edge N, held until the next edge.
- Write is visible to a read issued at the same edge (bypass) and to all later reads.
- Reset:
  - rst asserted immediately forces read_data to 0, asynchronously.
  - read_data stays 0 while rst is high.
  - The first edge after deassertion loads mem[read_addr].
- Reset mid-operation: a write on an edge while rst is high still completes. The read register stays 0.
- No handshake: wr_en and addresses are sampled every edge, with no back-pressure.
- Read port output is purely registered; no combinational path from inputs to read_data except the async reset.

## Test plan
- Reset: with rst high, read_data=0. Release rst with read_addr=5 on an unwritten array -> read_data=0 after the next edge.
- Basic write/read (data_bits=32): write 0xDEADBEEF to address 3. Next cycle read address 3 -> read_data=0xDEADBEEF one edge later.
- Byte lanes:
  - Write 0x11223344 with bytesel=1111 to address 7.
  - Then write 0xAABBCCDD with bytesel=0101.
  - Reading address 7 -> 0x11BB33DD.
  - bytesel=0000 write leaves 0x11BB33DD.
- Bypass: address 9 holds 0x00000000. On the same edge, write 0xCAFEF00D with bytesel=0011 and read address 9 -> read_data=0x0000F00D on that edge.
- Narrow instance (data_bits=1, nr_entries=128):
  - Write 1 to entries 0..127, then write 0 to entry 64.
  - Reading 63, 64 and 65 returns 1, 0, 1.
  - bytesel is ignored.
- Write during reset: with rst high, write 1 to entry 10. After rst falls, reading entry 10 returns 1, while read_data stayed 0 throughout reset.
